math_pipelined_sched: RTL and testbench



---
 rtl/math_pipelined_sched_pkg.sv | 24 ++
 rtl/math_pipelined_sched_rr_arbiter.sv | 35 +++
 rtl/math_pipelined_sched.sv | 193 +++++++++++++++++++
 tb/tb_math_pipelined_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/math_pipelined_sched_pkg.sv
// Shared opcode/state encodings and widths for the pipelined ALU scheduler.
package math_pipelined_sched_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_ANDR    = 3'd2,
    OP_ORR     = 3'd3,
    OP_XORR    = 3'd4,
    OP_EQ      = 3'd5,
    OP_NEQ     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/math_pipelined_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant_c,
  output logic [ID_W-1:0]  idx_c,
  output logic             any_c
);

  logic [N_REQ-1:0] rot;
  int unsigned      j;

  // Scan requesters starting at the pointer, wrapping at N_REQ-1.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    rot     = '0;
    j       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j   = (int'(ptr) + k) % N_REQ;
      rot = req >> j;
      if (en && !any_c && rot[0]) begin
        any_c   = 1'b1;
        idx_c   = ID_W'(j);
        grant_c = N_REQ'(1) << j;
      end
    end
  end

endmodule

// File: rtl/math_pipelined_sched.sv
// Round-robin scheduler sharing one pipelined ALU between N_REQ requesters.
// Operands are held for SETTLE_CYCLES before the selected result is captured.
// Optional counters: define MATH_PIPELINED_SCHED_PERF_EN for perf_ops/perf_stall.
module math_pipelined_sched
  import math_pipelined_sched_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned SETTLE_CYCLES = LATENCY + 1,
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned ID_W          = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*3-1:0]      req_op,
  input  logic [N_REQ*WIDTH-1:0]  req_a,
  input  logic [N_REQ*WIDTH-1:0]  req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
`ifdef MATH_PIPELINED_SCHED_PERF_EN
  output logic [31:0]             perf_ops,
  output logic [31:0]             perf_stall,
`endif
  output logic [WIDTH-1:0]        alu_i1,
  output logic [WIDTH-1:0]        alu_i2,
  output logic [WIDTH-1:0]        alu_i3,
  input  logic [WIDTH-1:0]        alu_sum,
  input  logic [WIDTH-1:0]        alu_sub,
  input  logic                    alu_and,
  input  logic                    alu_or,
  input  logic                    alu_xor,
  input  logic                    alu_eq,
  input  logic                    alu_neq
);

  state_e             state, state_d;
  logic [ID_W-1:0]    ptr, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   i1_d, i2_d, i3_d;
  logic               rsp_valid_d, rsp_err_d;
  logic [ID_W-1:0]    rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_d;

  logic [N_REQ-1:0]   grant_c;
  logic [ID_W-1:0]    idx_c;
  logic               any_c;
  logic [OP_W-1:0]    sel_op_c;
  logic [WIDTH-1:0]   sel_a_c, sel_b_c;
  logic [WIDTH-1:0]   result_c;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (state == ST_IDLE),
    .grant_c (grant_c),
    .idx_c   (idx_c),
    .any_c   (any_c)
  );

  assign req_ready = grant_c;

  // Route the winning requester's opcode and operands.
  always_comb begin
    sel_op_c = '0;
    sel_a_c  = '0;
    sel_b_c  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (idx_c == ID_W'(i)) begin
        sel_op_c = OP_W'(req_op >> (i * OP_W));
        sel_a_c  = WIDTH'(req_a >> (i * WIDTH));
        sel_b_c  = WIDTH'(req_b >> (i * WIDTH));
      end
    end
  end

  // Pick the ALU output for the latched opcode; flags land in bit 0.
  always_comb begin
    result_c = '0;
    unique case (op_q)
      OP_ADD:  result_c = alu_sum;
      OP_SUB:  result_c = alu_sub;
      OP_ANDR: result_c = WIDTH'(alu_and);
      OP_ORR:  result_c = WIDTH'(alu_or);
      OP_XORR: result_c = WIDTH'(alu_xor);
      OP_EQ:   result_c = WIDTH'(alu_eq);
      OP_NEQ:  result_c = WIDTH'(alu_neq);
      default: result_c = '0;
    endcase
  end

  // Next-state and next-output logic for the IDLE/HOLD/DONE sequence.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cnt_d       = cnt;
    op_d        = op_q;
    id_d        = id_q;
    i1_d        = alu_i1;
    i2_d        = alu_i2;
    i3_d        = alu_i3;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;
    unique case (state)
      ST_IDLE: begin
        if (any_c) begin
          op_d    = op_e'(sel_op_c);
          id_d    = idx_c;
          i1_d    = sel_a_c;
          i2_d    = sel_b_c;
          i3_d    = sel_b_c;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          ptr_d   = (idx_c == ID_W'(N_REQ - 1)) ? '0 : idx_c + ID_W'(1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          rsp_data_d  = result_c;
          rsp_err_d   = (op_q == OP_ILLEGAL);
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      op_q      <= OP_ADD;
      id_q      <= '0;
      alu_i1    <= '0;
      alu_i2    <= '0;
      alu_i3    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      op_q      <= op_d;
      id_q      <= id_d;
      alu_i1    <= i1_d;
      alu_i2    <= i2_d;
      alu_i3    <= i3_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_id    <= rsp_id_d;
      rsp_data  <= rsp_data_d;
    end
  end

`ifdef MATH_PIPELINED_SCHED_PERF_EN
  // Response handshake and back-pressure counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_valid && rsp_ready)  perf_ops   <= perf_ops + 32'd1;
      if (rsp_valid && !rsp_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_math_pipelined_sched.sv
// Randomized self-checking bench for math_pipelined_sched with an ALU stand-in.
module tb_math_pipelined_sched;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 4;
  localparam int S   = LAT + 1;
  localparam int IDW = 2;
  localparam int AW  = N * W;
  localparam int PW  = 2 * W + 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*3-1:0] req_op;
  logic [AW-1:0]  req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic [W-1:0]   alu_i1, alu_i2, alu_i3, alu_sum, alu_sub;
  logic           alu_and, alu_or, alu_xor, alu_eq, alu_neq;
`ifdef MATH_PIPELINED_SCHED_PERF_EN
  logic [31:0]    perf_ops, perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  int m_ops  = 0;
  int m_stall = 0;

  logic [2:0]   t_op [N];
  logic [W-1:0] t_a  [N];
  logic [W-1:0] t_b  [N];
  logic [PW-1:0] pipe [LAT];

  math_pipelined_sched #(
    .WIDTH(W), .LATENCY(LAT), .SETTLE_CYCLES(S), .N_REQ(N), .ID_W(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
`ifdef MATH_PIPELINED_SCHED_PERF_EN
    .perf_ops(perf_ops), .perf_stall(perf_stall),
`endif
    .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_i3(alu_i3),
    .alu_sum(alu_sum), .alu_sub(alu_sub),
    .alu_and(alu_and), .alu_or(alu_or), .alu_xor(alu_xor),
    .alu_eq(alu_eq), .alu_neq(alu_neq)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in: results appear LAT edges after the operands change.
  initial for (int k = 0; k < LAT; k++) pipe[k] = '0;
  always @(posedge clk) begin
    pipe[0] <= {alu_i1 + alu_i2, alu_i1 - alu_i2, &alu_i1, |alu_i1, ^alu_i1,
                alu_i1 == alu_i2, alu_i1 != alu_i2};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign {alu_sum, alu_sub, alu_and, alu_or, alu_xor, alu_eq, alu_neq} = pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    t_op[i] = op; t_a[i] = a; t_b[i] = b;
  endtask

  task automatic drive_reqs();
    req_op = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_op = req_op | ((N*3)'(t_op[i]) << (i * 3));
      req_a  = req_a  | (AW'(t_a[i]) << (i * W));
      req_b  = req_b  | (AW'(t_b[i]) << (i * W));
    end
  endtask

  function automatic int winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (((v >> j) & N'(1)) != '0) return j;
    end
    return 0;
  endfunction

  task automatic model_result(input logic [2:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, output logic [W-1:0] d,
                              output logic e);
    int ones;
    ones = 0;
    for (int k = 0; k < W; k++) ones += int'((a >> k) & W'(1));
    e = 1'b0;
    case (op)
      3'd0:    d = W'(int'(a) + int'(b));
      3'd1:    d = W'(int'(a) - int'(b));
      3'd2:    d = (ones == W) ? W'(1) : W'(0);
      3'd3:    d = (ones != 0) ? W'(1) : W'(0);
      3'd4:    d = W'(ones % 2);
      3'd5:    d = (a == b) ? W'(1) : W'(0);
      3'd6:    d = (a != b) ? W'(1) : W'(0);
      default: begin d = '0; e = 1'b1; end
    endcase
  endtask

  task automatic check_perf();
`ifdef MATH_PIPELINED_SCHED_PERF_EN
    check("perf_ops", perf_ops, 32'(m_ops));
    check("perf_stall", perf_stall, 32'(m_stall));
`endif
  endtask

  // One full request/response transaction; called #1 after an edge in IDLE.
  task automatic txn(input logic [N-1:0] vmask, input int stall,
                     output logic [W-1:0] got, output int got_id);
    int w;
    logic [W-1:0] exp_d, a_w, b_w;
    logic exp_e;
    req_valid = vmask;
    drive_reqs();
    #1;
    w = winner(vmask);
    check("grant", 32'(req_ready), 32'(N'(1) << w));
    a_w = t_a[w];
    b_w = t_b[w];
    model_result(t_op[w], a_w, b_w, exp_d, exp_e);
    mptr = (w + 1) % N;
    step();
    check("opnd_a", 32'(alu_i1), 32'(a_w));
    check("opnd_b", 32'(alu_i2), 32'(b_w));
    check("opnd_b3", 32'(alu_i3), 32'(b_w));
    check("ready_hold", 32'(req_ready), 32'(0));
    req_valid = N'($urandom);
    rsp_ready = 1'($urandom);
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    for (int k = 1; k < S; k++) begin
      step();
      check("hold_valid", 32'(rsp_valid), 32'(0));
      check("hold_ready", 32'(req_ready), 32'(0));
    end
    check("hold_opnd", 32'(alu_i1), 32'(a_w));
    rsp_ready = 1'b0;
    step();
    check("rsp_valid", 32'(rsp_valid), 32'(1));
    check("rsp_data", 32'(rsp_data), 32'(exp_d));
    check("rsp_id", 32'(rsp_id), 32'(w));
    check("rsp_err", 32'(rsp_err), 32'(exp_e));
    got = rsp_data;
    got_id = int'(rsp_id);
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_valid", 32'(rsp_valid), 32'(1));
      check("stall_data", 32'(rsp_data), 32'(exp_d));
      check("stall_id", 32'(rsp_id), 32'(w));
      check("stall_ready", 32'(req_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    #1;
    check("bubble", 32'(req_ready), 32'(0));
    step();
    check("rsp_drop", 32'(rsp_valid), 32'(0));
    m_ops++;
    m_stall += stall;
    check_perf();
    rsp_ready = 1'($urandom);
  endtask

  initial begin
    logic [W-1:0] got;
    int gid;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 3'd0, '0, '0);
    drive_reqs();
    #1;
    check("rst_valid", 32'(rsp_valid), 32'(0));
    check("rst_data", 32'(rsp_data), 32'(0));
    check("rst_id", 32'(rsp_id), 32'(0));
    check("rst_err", 32'(rsp_err), 32'(0));
    check("rst_i1", 32'(alu_i1), 32'(0));
    check("rst_i2", 32'(alu_i2), 32'(0));
    check("rst_i3", 32'(alu_i3), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    check_perf();
    #20 rst_n = 1'b1;
    step();

    // All requesters valid: strict rotation starting at 0.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) set_req(i, 3'(i), W'($urandom), W'($urandom));
      txn(N'(4'hF), 0, got, gid);
      check("rr_order", 32'(gid), 32'(r % N));
    end

    // Directed opcodes from a single requester, which wins every time.
    set_req(0, 3'd0, 16'h00FF, 16'h0001); txn(N'(1), 0, got, gid);
    check("dir_add", 32'(got), 32'h0100);
    set_req(0, 3'd1, 16'h0000, 16'h0001); txn(N'(1), 0, got, gid);
    check("dir_sub", 32'(got), 32'hFFFF);
    set_req(0, 3'd2, 16'hFFFF, 16'h0000); txn(N'(1), 0, got, gid);
    check("dir_andr", 32'(got), 32'h0001);
    set_req(0, 3'd4, 16'h0007, 16'h0000); txn(N'(1), 0, got, gid);
    check("dir_xorr", 32'(got), 32'h0001);
    set_req(0, 3'd5, 16'h1234, 16'h1234); txn(N'(1), 0, got, gid);
    check("dir_eq", 32'(got), 32'h0001);
    set_req(0, 3'd6, 16'h1234, 16'h1234); txn(N'(1), 0, got, gid);
    check("dir_neq", 32'(got), 32'h0000);
    check("dir_id", 32'(gid), 32'(0));
    set_req(0, 3'd7, 16'hABCD, 16'h1111); txn(N'(1), 0, got, gid);
    check("dir_ill", 32'(got), 32'h0000);

    // Long back-pressure on the response channel.
    set_req(1, 3'd0, 16'h1000, 16'h0234); txn(N'(2), 10, got, gid);
    check("stall_result", 32'(got), 32'h1234);

    // Reset during HOLD discards the op and clears the pointer.
    for (int i = 0; i < N; i++) set_req(i, 3'd0, 16'h0101, 16'h0202);
    req_valid = N'(4'b0100);
    drive_reqs();
    step();
    step();
    step();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(rsp_valid), 32'(0));
    check("abort_i1", 32'(alu_i1), 32'(0));
    check("abort_i2", 32'(alu_i2), 32'(0));
    check("abort_ready", 32'(req_ready), 32'(0));
    mptr = 0;
    m_ops = 0;
    m_stall = 0;
    check_perf();
    #2 rst_n = 1'b1;
    step();
    for (int k = 0; k < S + 3; k++) begin
      check("abort_norsp", 32'(rsp_valid), 32'(0));
      step();
    end
    txn(N'(4'hF), 0, got, gid);
    check("abort_ptr0", 32'(gid), 32'(0));

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        logic [W-1:0] a;
        a = W'($urandom);
        set_req(i, 3'($urandom_range(0, 7)), a,
                ($urandom_range(0, 3) == 0) ? a : W'($urandom));
      end
      txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3), got, gid);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
